// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage
//  Purpose  : RISC-V EX stage (forwarding, ALU, branch compare, target) with
//             the EX/MEM pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      ImmSrcE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            branch_condition,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [2:0]      funct3M
);

    localparam logic [1:0] c_FWD_W   = 2'b01;
    localparam logic [1:0] c_FWD_M   = 2'b10;
    localparam logic [2:0] c_IMM_I   = 3'b000;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_write_data;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_jalr_sum;
    logic [4:0]      w_shamt;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;

    logic            r_reg_write;
    logic            r_mem_write;
    logic [1:0]      r_result_src;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_pc_plus4;
    logic [2:0]      r_funct3;

    // Code 10 forwards this stage's own registered result (back-to-back dependency)
    always_comb begin
        case (ForwardAE)
            c_FWD_W: w_src_a = ResultW;
            c_FWD_M: w_src_a = r_alu_result;
            default: w_src_a = RD1E;
        endcase
        case (ForwardBE)
            c_FWD_W: w_write_data = ResultW;
            c_FWD_M: w_write_data = r_alu_result;
            default: w_write_data = RD2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;
    assign w_shamt = w_src_b[4:0];

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            4'b0000: w_alu_result = w_src_a + w_src_b;
            4'b0001: w_alu_result = w_src_a - w_src_b;
            4'b0010: w_alu_result = w_src_a & w_src_b;
            4'b0011: w_alu_result = w_src_a | w_src_b;
            4'b0100: w_alu_result = w_src_a ^ w_src_b;
            4'b0101: w_alu_result = w_src_a << w_shamt;
            4'b0110: w_alu_result = w_src_a >> w_shamt;
            4'b0111: w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
            4'b1000: w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            4'b1001: w_alu_result = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
            4'b1010: w_alu_result = w_src_b;
            4'b1011: w_alu_result = PCE + ImmExtE;
            default: w_alu_result = '0;
        endcase
    end

    // Branch compare uses the forwarded RD2, never the immediate-muxed operand
    assign w_eq  = (w_src_a == w_write_data);
    assign w_lt  = ($signed(w_src_a) < $signed(w_write_data));
    assign w_ltu = (w_src_a < w_write_data);

    always_comb begin
        branch_condition = 1'b0;
        case (funct3E)
            3'b000:  branch_condition = w_eq;
            3'b001:  branch_condition = ~w_eq;
            3'b100:  branch_condition = w_lt;
            3'b101:  branch_condition = ~w_lt;
            3'b110:  branch_condition = w_ltu;
            3'b111:  branch_condition = ~w_ltu;
            default: branch_condition = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_src_a + ImmExtE;
    assign PCTargetE  = (JumpE && (ImmSrcE == c_IMM_I)) ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                                          : PCE + ImmExtE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_funct3     <= '0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_alu_result <= w_alu_result;
            r_write_data <= w_write_data;
            r_rd         <= RdE;
            r_pc_plus4   <= PCPlus4E;
            r_funct3     <= funct3E;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign RdM        = r_rd;
    assign PCPlus4M   = r_pc_plus4;
    assign funct3M    = r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_stage
//  Purpose  : Randomized and directed bench for execute_stage against a
//             behavioural model of the EX stage and EX/MEM register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  ImmSrcE, funct3E;
    logic [31:0] PCE, PCPlus4E, ImmExtE, RD1E, RD2E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        branch_condition;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;

    int n_tests = 0;
    int n_fail  = 0;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ImmSrcE(ImmSrcE),
        .funct3E(funct3E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .RD1E(RD1E), .RD2E(RD2E), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .branch_condition(branch_condition), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .funct3M(funct3M)
    );

    always #5 clk = ~clk;

    // Model state: what the EX/MEM register must hold
    logic        m_valid = 1'b0;
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] pc,
                                              input logic [31:0] imm);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b) + 1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            4'd11: return pc + imm;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_model(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return slt;
            3'd5: return !slt;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_src_a();
        return fwd(ForwardAE, RD1E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] exp_wd();
        return fwd(ForwardBE, RD2E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] exp_target();
        logic [31:0] a;
        a = exp_src_a();
        if (JumpE && ImmSrcE == 3'd0) return (a + ImmExtE) & 32'hFFFF_FFFE;
        return PCE + ImmExtE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_rw <= 1'b0; m_mw <= 1'b0; m_rs <= '0; m_alu <= '0;
            m_wd <= '0; m_rd <= '0; m_pc4 <= '0; m_f3 <= '0;
        end else if (m_valid) begin
            m_rw  <= RegWriteE;
            m_mw  <= MemWriteE;
            m_rs  <= ResultSrcE;
            m_alu <= alu_model(ALUControlE, exp_src_a(), ALUSrcE ? ImmExtE : exp_wd(),
                               PCE, ImmExtE);
            m_wd  <= exp_wd();
            m_rd  <= RdE;
            m_pc4 <= PCPlus4E;
            m_f3  <= funct3E;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("branch_condition", 32'(branch_condition),
                32'(br_model(funct3E, exp_src_a(), exp_wd())));
            chk("PCTargetE", PCTargetE, exp_target());
            chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
            chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
            chk("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
            chk("ALUResultM", ALUResultM, m_alu);
            chk("WriteDataM", WriteDataM, m_wd);
            chk("RdM", 32'(RdM), 32'(m_rd));
            chk("PCPlus4M", PCPlus4M, m_pc4);
            chk("funct3M", 32'(funct3M), 32'(m_f3));
        end
    end

    task automatic randomize_in();
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); JumpE = 1'($urandom);
        ALUSrcE = 1'($urandom); ResultSrcE = 2'($urandom); ALUControlE = 4'($urandom);
        ImmSrcE = 3'($urandom_range(0, 4)); funct3E = 3'($urandom);
        PCE = $urandom; PCPlus4E = PCE + 4; ImmExtE = $urandom;
        RD1E = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        RdE = 5'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ResultW = $urandom;
    endtask

    task automatic clear_in();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; ALUSrcE = 0; ResultSrcE = 0;
        ALUControlE = 0; ImmSrcE = 0; funct3E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0;
        RD1E = 0; RD2E = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] saved_rd;
    logic [2:0] f3_list [4] = '{3'd4, 3'd6, 3'd7, 3'd2};
    logic       bc_exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        randomize_in();
        step();
        randomize_in();
        step();
        chk("reset ALUResultM", ALUResultM, 32'd0);
        chk("reset RegWriteM", 32'(RegWriteM), 32'd0);
        chk("reset PCPlus4M", PCPlus4M, 32'd0);
        chk("reset RdM", 32'(RdM), 32'd0);

        rst = 1'b0;
        randomize_in();
        RegWriteE = 1'b1;
        saved_rd = RdE;
        step();
        chk("release RdM", 32'(RdM), 32'(saved_rd));
        chk("release RegWriteM", 32'(RegWriteM), 32'd1);

        clear_in(); RD1E = 32'd5; ALUSrcE = 1; ImmExtE = 32'hFFFF_FFF9;
        step();
        chk("ADD 5-7", ALUResultM, 32'hFFFF_FFFE);
        clear_in(); ALUControlE = 4'd7; RD1E = 32'h8000_0000; ALUSrcE = 1; ImmExtE = 32'd4;
        step();
        chk("SRA", ALUResultM, 32'hF800_0000);

        clear_in(); RD1E = 32'd4; ALUSrcE = 1; ImmExtE = 32'd6;
        step();
        chk("ADD 10", ALUResultM, 32'd10);
        clear_in(); ForwardAE = 2'b10; ALUControlE = 4'd1; ALUSrcE = 1; ImmExtE = 32'd3;
        RD1E = 32'd999;
        step();
        chk("fwd SUB", ALUResultM, 32'd7);
        clear_in(); MemWriteE = 1; ForwardBE = 2'b01; ResultW = 32'd9; RD2E = 32'd55;
        step();
        chk("fwd store", WriteDataM, 32'd9);
        chk("store MemWriteM", 32'(MemWriteM), 32'd1);

        clear_in(); RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            funct3E = f3_list[i];
            #1;
            chk($sformatf("branch f3=%0d", f3_list[i]), 32'(branch_condition), 32'(bc_exp[i]));
            step();
        end
        chk("branch target", PCTargetE, 32'hF8);

        clear_in(); JumpE = 1; ImmSrcE = 3'd0; RD1E = 32'h1003; ImmExtE = 32'd2;
        #1;
        chk("JALR target", PCTargetE, 32'h1004);
        step();
        clear_in(); JumpE = 1; ImmSrcE = 3'd3; PCE = 32'h40; ImmExtE = 32'h20;
        PCPlus4E = 32'h44; RegWriteE = 1; RdE = 5'd1;
        #1;
        chk("JAL target", PCTargetE, 32'h60);
        step();
        chk("JAL PCPlus4M", PCPlus4M, 32'h44);

        clear_in();
        step();
        chk("bubble RegWriteM", 32'(RegWriteM), 32'd0);
        chk("bubble MemWriteM", 32'(MemWriteM), 32'd0);
        chk("bubble RdM", 32'(RdM), 32'd0);

        for (int c = 0; c < 400; c++) begin
            randomize_in();
            rst = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
